// File: rtl/reg_bank_sequencer_pkg.sv
// Shared types, default sizing and the pattern function for reg_bank_sequencer.
// SEQ_INVERT_PASS_EN adds the states for the second, inverted-data pass.
package reg_bank_sequencer_pkg;

    localparam int unsigned SEQ_ADDR_W = 2;
    localparam int unsigned SEQ_DATA_W = 4;
    localparam int unsigned SEQ_SEED   = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_READ   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
`ifdef SEQ_INVERT_PASS_EN
        ,
        ST_WRITE2 = 3'd5,
        ST_READ2  = 3'd6,
        ST_CHECK2 = 3'd7
`endif
    } seq_state_e;

    // Pattern word (addr + seed), optionally inverted; callers truncate to their data width.
    function automatic logic [31:0] seq_pattern(input logic [31:0] addr,
                                                input logic [31:0] seed,
                                                input logic        invert);
        logic [31:0] sum;
        sum = addr + seed;
        return invert ? ~sum : sum;
    endfunction

endpackage

// File: rtl/seq_pattern_gen.sv
// Combinational write/expected data generator shared by the write and check paths.
// The invert input is only driven high when SEQ_INVERT_PASS_EN is defined.
module seq_pattern_gen
    import reg_bank_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = SEQ_ADDR_W,
    parameter int unsigned DATA_W = SEQ_DATA_W,
    parameter int unsigned SEED   = SEQ_SEED
) (
    input  logic [ADDR_W-1:0] cnt_i,
    input  logic              invert_i,
    output logic [DATA_W-1:0] pat_c_o
);

    // Truncate the pattern word to the bus width.
    assign pat_c_o = DATA_W'(seq_pattern(32'(cnt_i), 32'(SEED), invert_i));

endmodule

// File: rtl/reg_bank_sequencer.sv
// Register-bank self-test: writes (addr+SEED) to every entry, reads each back and
// counts mismatches. Define SEQ_INVERT_PASS_EN for an extra pass with inverted data.
module reg_bank_sequencer
    import reg_bank_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W = SEQ_ADDR_W,
    parameter int unsigned DATA_W = SEQ_DATA_W,
    parameter int unsigned SEED   = SEQ_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_count
);

    localparam int unsigned       ERR_W     = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    seq_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] exp_q, pat_c;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              start_q;
    logic              inv_d;
`ifdef SEQ_INVERT_PASS_EN
    logic              inv_q;
`endif
    logic              wr_en_q, rd_en_q, busy_q, done_q, pass_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              last_c, launch_c, mismatch_c;

    assign last_c     = (cnt_q == LAST_ADDR);
    // Rising-edge qualified so a start held high launches exactly one run.
    assign launch_c   = (state_q == ST_IDLE) && start && !start_q;
    assign mismatch_c = (rd_data != exp_q);

    seq_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_pattern (
        .cnt_i    (cnt_d),
        .invert_i (inv_d),
        .pat_c_o  (pat_c)
    );

    // Next address counter, pass-invert flag and error count.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
`ifdef SEQ_INVERT_PASS_EN
        inv_d = inv_q;
`else
        inv_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (launch_c) begin
                    cnt_d = '0;
                    err_d = '0;
                    inv_d = 1'b0;
                end
            end
            ST_WRITE: cnt_d = last_c ? '0 : cnt_q + ADDR_W'(1);
            ST_CHECK: begin
                if (mismatch_c) err_d = err_q + ERR_W'(1);
                if (!last_c) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
`ifdef SEQ_INVERT_PASS_EN
                else begin
                    cnt_d = '0;
                    inv_d = 1'b1;
                end
`endif
            end
`ifdef SEQ_INVERT_PASS_EN
            ST_WRITE2: cnt_d = last_c ? '0 : cnt_q + ADDR_W'(1);
            ST_CHECK2: begin
                if (mismatch_c) err_d = err_q + ERR_W'(1);
                if (!last_c) cnt_d = cnt_q + ADDR_W'(1);
            end
`endif
            default: ;
        endcase
    end

    // Sequencer FSM; strobes and addresses are registered to line up with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            exp_q     <= '0;
            err_q     <= '0;
            start_q   <= 1'b0;
`ifdef SEQ_INVERT_PASS_EN
            inv_q     <= 1'b0;
`endif
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            exp_q     <= pat_c;
            err_q     <= err_d;
            start_q   <= start;
`ifdef SEQ_INVERT_PASS_EN
            inv_q     <= inv_d;
`endif
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            done_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (launch_c) begin
                        state_q   <= ST_WRITE;
                        busy_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_d;
                        wr_data_q <= pat_c;
                    end
                end
                ST_WRITE: begin
                    if (last_c) begin
                        state_q   <= ST_READ;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= cnt_d;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_d;
                        wr_data_q <= pat_c;
                    end
                end
                ST_READ: state_q <= ST_CHECK;
                ST_CHECK: begin
                    if (!last_c) begin
                        state_q   <= ST_READ;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= cnt_d;
                    end else begin
`ifdef SEQ_INVERT_PASS_EN
                        state_q   <= ST_WRITE2;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_d;
                        wr_data_q <= pat_c;
`else
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        pass_q    <= (err_d == '0);
`endif
                    end
                end
`ifdef SEQ_INVERT_PASS_EN
                ST_WRITE2: begin
                    if (last_c) begin
                        state_q   <= ST_READ2;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= cnt_d;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= cnt_d;
                        wr_data_q <= pat_c;
                    end
                end
                ST_READ2: state_q <= ST_CHECK2;
                ST_CHECK2: begin
                    if (!last_c) begin
                        state_q   <= ST_READ2;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= cnt_d;
                    end else begin
                        state_q   <= ST_DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        pass_q    <= (err_d == '0);
                    end
                end
`endif
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Bench for reg_bank_sequencer: bank model, offset-based reference model, per-cycle compare,
// directed scenarios and a randomized phase. Honours SEQ_INVERT_PASS_EN.
module tb_reg_bank_sequencer;

    localparam int AW = 2;
    localparam int DW = 4;
    localparam int N  = 4;
`ifdef SEQ_INVERT_PASS_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int BUSY    = 3 * N * PASSES;
    localparam int DONE_AT = (PASSES == 2) ? 25 : 13;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          wr_en, rd_en, busy, done, pass;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data = '0;
    logic [AW+1:0] err_count;

    reg_bank_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: offset of the current run (0 = idle, 1..BUSY busy, BUSY+1 = done cycle).
    int m_off = 0;
    int m_err = 0;
    bit m_pass = 1'b0;
    bit m_start_prev = 1'b0;

    // Readback corruption control: c_pass < 0 means every pass.
    bit        c_en = 1'b0;
    int        c_addr = 0;
    int        c_pass = -1;
    logic [3:0] c_val = 4'h0;

    logic [DW-1:0] mem [N];
    int wr_log[$];
    int done_cnt = 0;
    int busy_cnt = 0;
    int exp_wr[8] = '{3, 4, 5, 6, 12, 11, 10, 9};

    function automatic logic [3:0] pat(input int a, input int p);
        logic [3:0] v;
        v = 4'(a + 3);
        return (p != 0) ? ~v : v;
    endfunction

    function automatic bit hit(input int a, input int p);
        return c_en && (a == c_addr) && (c_pass < 0 || c_pass == p);
    endfunction

    // 1 when offset o is a check cycle whose readback is corrupted to a wrong value.
    function automatic int err_incr(input int o);
        int p, r, q, a;
        if (o < 1 || o > BUSY) return 0;
        p = (o - 1) / (3 * N);
        r = (o - 1) % (3 * N);
        if (r < N) return 0;
        q = r - N;
        if (q % 2 == 0) return 0;
        a = q / 2;
        return (hit(a, p) && c_val != pat(a, p)) ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_off <= 0;
            m_err <= 0;
            m_pass <= 1'b0;
            m_start_prev <= 1'b0;
        end else begin
            m_start_prev <= start;
            if (m_off == 0) begin
                if (start && !m_start_prev) begin
                    m_off <= 1;
                    m_err <= 0;
                    m_pass <= 1'b0;
                end
            end else if (m_off <= BUSY) begin
                m_err <= m_err + err_incr(m_off);
                m_off <= m_off + 1;
                if (m_off == BUSY) m_pass <= ((m_err + err_incr(m_off)) == 0);
            end else begin
                m_off <= 0;
            end
        end
    end

    // Register bank with registered readback.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= hit(int'(rd_addr), (m_off >= 1) ? (m_off - 1) / (3 * N) : 0)
                              ? c_val : mem[rd_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic compare();
        int o, p, r, q;
        bit ew, er, eb, ed;
        int ewa, ewd, era;
        o = m_off;
        ew = 0; er = 0; eb = 0; ed = 0;
        ewa = 0; ewd = 0; era = 0;
        if (o >= 1 && o <= BUSY) begin
            eb = 1;
            p = (o - 1) / (3 * N);
            r = (o - 1) % (3 * N);
            if (r < N) begin
                ew = 1;
                ewa = r;
                ewd = int'(pat(r, p));
            end else begin
                q = r - N;
                if (q % 2 == 0) begin
                    er = 1;
                    era = q / 2;
                end
            end
        end else if (o == BUSY + 1) begin
            ed = 1;
        end
        chk("ctrl{wr,rd,busy,done,pass}", 32'({wr_en, rd_en, busy, done, pass}),
            32'({ew, er, eb, ed, m_pass}));
        chk("err_count", 32'(err_count), 32'(m_err));
        if (ew) begin
            chk("wr_addr", 32'(wr_addr), 32'(ewa));
            chk("wr_data", 32'(wr_data), 32'(ewd));
        end
        if (er) chk("rd_addr", 32'(rd_addr), 32'(era));
        if (wr_en === 1'b1) wr_log.push_back(int'(wr_data));
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic step();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_mon();
        wr_log.delete();
        done_cnt = 0;
        busy_cnt = 0;
    endtask

    // One-cycle start pulse, then a bounded wait; returns the step at which done was seen (-1 if never).
    task automatic run_pulse(output int done_step);
        done_step = -1;
        start = 1'b1;
        for (int k = 1; k <= BUSY + 10; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (done === 1'b1 && done_step < 0) done_step = k;
        end
    endtask

    initial begin
        int ds;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        clear_mon();
        repeat (5) step();
        chk("idle_writes", 32'(wr_log.size()), 32'(0));
        chk("idle_busy_cycles", 32'(busy_cnt), 32'(0));

        // Clean run with a correct bank.
        clear_mon();
        run_pulse(ds);
        chk("done_step", 32'(ds), 32'(DONE_AT));
        chk("busy_cycles", 32'(busy_cnt), 32'(BUSY));
        chk("done_count", 32'(done_cnt), 32'(1));
        chk("write_count", 32'(wr_log.size()), 32'(4 * PASSES));
        for (int i = 0; i < 4 * PASSES; i++)
            if (i < wr_log.size()) chk("write_sequence", 32'(wr_log[i]), 32'(exp_wr[i]));
        chk("clean_pass", 32'(pass), 32'(1));
        chk("clean_err", 32'(err_count), 32'(0));

        // Readback of addr2 forced to F in the first pass.
        c_en = 1'b1; c_addr = 2; c_val = 4'hF; c_pass = 0;
        clear_mon();
        run_pulse(ds);
        chk("corrupt_err", 32'(err_count), 32'(1));
        chk("corrupt_pass", 32'(pass), 32'(0));
        chk("corrupt_done_count", 32'(done_cnt), 32'(1));
        c_en = 1'b0;

        // Start held high: exactly one run.
        clear_mon();
        start = 1'b1;
        repeat (20) step();
        start = 1'b0;
        repeat (BUSY + 10) step();
        chk("held_start_runs", 32'(done_cnt), 32'(1));
        clear_mon();
        run_pulse(ds);
        chk("rerun_done_count", 32'(done_cnt), 32'(1));
        chk("rerun_pass", 32'(pass), 32'(1));

        // Reset during the second READ.
        clear_mon();
        start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 1) start = 1'b0;
        end
        chk("second_read_strobe", 32'({rd_en, rd_addr}), 32'({1'b1, 2'd1}));
        rst = 1'b1;
        step();
        chk("reset_outputs", 32'({wr_en, rd_en, busy, done, pass, err_count}), 32'(0));
        rst = 1'b0;
        repeat (5) step();
        chk("reset_no_done", 32'(done_cnt), 32'(0));
        clear_mon();
        run_pulse(ds);
        chk("post_reset_busy", 32'(busy_cnt), 32'(BUSY));
        chk("post_reset_pass", 32'(pass), 32'(1));

`ifdef SEQ_INVERT_PASS_EN
        // Corrupt addr0 in the inverted pass only.
        c_en = 1'b1; c_addr = 0; c_val = 4'h0; c_pass = 1;
        clear_mon();
        run_pulse(ds);
        chk("pass2_corrupt_err", 32'(err_count), 32'(1));
        chk("pass2_corrupt_pass", 32'(pass), 32'(0));
        c_en = 1'b0;
`endif

        // Randomized start traffic, corruption settings and occasional resets.
        clear_mon();
        for (int k = 0; k < 3000; k++) begin
            step();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) rst = 1'b1;
            if (m_off == 0 && !start && $urandom_range(0, 3) == 0) begin
                c_en   = 1'($urandom_range(0, 1));
                c_addr = int'($urandom_range(0, 3));
                c_val  = 4'($urandom_range(0, 15));
                c_pass = int'($urandom_range(0, PASSES)) - 1;
            end
            start = ($urandom_range(0, 5) == 0);
        end
        start = 1'b0;
        rst = 1'b0;
        repeat (BUSY + 4) step();
        chk("random_runs_completed", 32'(done_cnt > 10), 32'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
